// File: rtl/pulse_monitor_pkg.sv
// rtl/pulse_monitor_pkg.sv - shared types and defaults for the pulse monitor
package pulse_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/pulse_monitor_edge.sv
// rtl/pulse_monitor_edge.sv - rise/fall detector on a same-domain single-bit input
module pulse_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic prev;

    // prev resets low so an input held high out of reset reads as a rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev <= 1'b0;
        end else begin
            prev <= din;
        end
    end

    assign rise = din & ~prev;
    assign fall = ~din & prev;

endmodule

// File: rtl/pulse_monitor.sv
// rtl/pulse_monitor.sv - period/high-time measurement with valid/ready result port
module pulse_monitor
    import pulse_monitor_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pulse_in,
    input  logic             clr_err,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_width,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wid_q, wid_d;
    logic             rise, fall;
    logic             close, to_hit, drop;

    pulse_edge_detect u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (pulse_in),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wid_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wid_q   <= wid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wid_d   = wid_q;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
            wid_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = ONE;
                        wid_d   = ONE;
                    end
                end
                HIGH, LOW: begin
                    // a rise always closes the open measurement, even at the timeout count
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = ONE;
                        wid_d   = ONE;
                    end else if (cnt_q == TO_CNT) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        wid_d   = '0;
                    end else if (state_q == HIGH && !fall) begin
                        cnt_d = cnt_q + ONE;
                        wid_d = wid_q + ONE;
                    end else begin
                        state_d = LOW;
                        cnt_d   = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    wid_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        close  = en && (state_q != IDLE) && rise;
        to_hit = en && (state_q != IDLE) && !rise && (cnt_q == TO_CNT);
        drop   = close && meas_valid && !meas_ready;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_width  <= '0;
            timeout     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            timeout <= to_hit;
            overrun <= drop | (overrun & ~clr_err);
            if (close && !drop) begin
                meas_valid  <= 1'b1;
                meas_period <= cnt_q;
                meas_width  <= wid_q;
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/pulse_monitor.md
Name: pulse_monitor

Overview:
Downstream consumer of the periodic pulse generator. Measures the period and high-time of an incoming single-bit pulse train in clock cycles. Presents each completed measurement on a valid/ready output port. Flags missing pulses (timeout) and dropped results (overrun). Same clock domain as the pulse source, so there is no input synchroniser.

Parameters:
CNT_W, 32, width of the period and width counters and result fields
TIMEOUT, 1024, cycles without a rising edge before a timeout is declared; must be in the range 2 .. 2^CNT_W-1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  measurement enable
pulse_in  in  1  pulse train from the upstream pulse generator
clr_err  in  1  synchronous clear of the sticky overrun flag
meas_valid  out  1  result available
meas_ready  in  1  downstream accepts the result
meas_period  out  CNT_W  cycles from one rising edge to the next
meas_width  out  CNT_W  cycles pulse_in stayed high after the rising edge
timeout  out  1  one-cycle strobe: no rising edge within TIMEOUT cycles
overrun  out  1  sticky: a completed result was dropped

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, state=IDLE, cnt=0, wid=0, prev=0.
- Rising edge detect: rise = pulse_in & ~prev. prev is registered every cycle. Because prev resets to 0, a pulse_in held high out of reset counts as a rise.
- FSM states:
  - IDLE: on rise -> HIGH, cnt<=1, wid<=1. No result is produced.
  - HIGH: if rise (not possible from HIGH, since it needs prev=0) the rise rule below applies. Else if pulse_in=1: cnt++, wid++. Else: -> LOW, cnt++, wid held.
  - LOW: if rise: close the measurement, cnt<=1, wid<=1, -> HIGH. Else cnt++.
- Closing a measurement on rise in LOW: result = {period=cnt, width=wid}, using the register values in that cycle. meas_valid is asserted the following cycle, so latency is 1 cycle after the closing edge.
- Back-to-back: every rising edge after the first closes one measurement and opens the next. There are no gap cycles.
- Timeout: in HIGH or LOW, if cnt==TIMEOUT and there is no rise this cycle:
  - timeout=1 for exactly the next cycle;
  - state -> IDLE, cnt=0, wid=0;
  - the partial measurement is discarded.
- Simultaneous rise and cnt==TIMEOUT: the rise wins and no timeout is raised.
- A constant-high input never leaves HIGH, so it times out. This is the required behaviour.
- en=0: state is forced to IDLE and cnt and wid are cleared next cycle. A held result stays valid until it is accepted. prev keeps tracking pulse_in.
- Output handshake:
  - While meas_valid=1, meas_period and meas_width are stable.
  - A transfer occurs on meas_valid & meas_ready.
  - Transfer with no new result: meas_valid<=0.
  - New result while meas_valid=1 & meas_ready=0: the new result is dropped, overrun<=1, and the held data is unchanged.
  - New result in the same cycle as a transfer: load the new result, meas_valid stays 1, no overrun.
- overrun: sticky until clr_err=1. If clr_err=1 coincides with a new overrun event, the set wins.
- Counter width: TIMEOUT < 2^CNT_W, so cnt never wraps. wid <= cnt always holds.

Decomposition:
- Shared package: FSM state typedef (IDLE, HIGH, LOW, 2-bit encoding) and the default CNT_W and TIMEOUT constants.
- Sub-module pulse_edge_detect:
  - ports clk, rst, din;
  - outputs rise and fall;
  - prev register reset to 0.
- The FSM, counters and output register stay in pulse_monitor.

Test Plan:
1. Hold rst=0 for 5 cycles with pulse_in=1 -> all outputs are 0. Release rst with en=1 -> state goes HIGH on the first cycle and no meas_valid appears.
2. Periodic input, 3 high / 7 low, meas_ready=1 -> after the second rise, meas_valid pulses with period=10, width=3. This repeats every 10 cycles with no gaps.
3. Same stimulus with meas_ready=0 for 25 cycles -> the first result (10,3) is held and overrun=1 after the next rise. Then meas_ready=1 -> transfer occurs. Then clr_err=1 -> overrun=0.
4. TIMEOUT=64, one rise then pulse_in=0 -> timeout=1 for exactly one cycle, 64 cycles after the rise count began. State is IDLE, and the next rise yields no result.
5. en=0 mid-LOW, then en=1 with the 3/7 input -> the first result after re-enable is a full (10,3), not a partial one.
6. rst=0 asserted mid-measurement while meas_valid=1 -> meas_valid, overrun and timeout are immediately 0 (asynchronous). After release, operation restarts from IDLE.
